ref_force_wb_collector: RTL and testbench

Collects the per-lane accumulated reference-particle forces from the seven force accumulators in an RL LJ evaluation unit (lanes 0–6, one per accumulator index). It buffers each lane in a small FIFO and serializes the entries, round-robin, onto a single valid/ready writeback port toward the force cache. It also tracks writeback rounds: a round opens on any accumulator `start_wb` pulse and closes once every buffered force has been handed off.

---
 rtl/ref_force_wb_collector.sv | 196 +++++++++++++++++++
 tb/tb_ref_force_wb_collector.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_force_wb_collector.sv
// Gathers accumulated reference forces from seven accumulator lanes, buffers
// each lane in a 2-deep FIFO and drains them round-robin onto one writeback port.
module ref_force_wb_collector #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 8,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int NUM_LANES         = 7,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_LANES-1:0]            in_valid,
  input  logic [NUM_LANES-1:0]            in_start_wb,
  input  logic [NUM_LANES*ID_WIDTH-1:0]   in_id,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_force_x,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_force_y,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_force_z,
  output logic                            in_stall,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2:0]                      out_lane,
  output logic [ID_WIDTH-1:0]             out_id,
  output logic [DATA_WIDTH-1:0]           out_force_x,
  output logic [DATA_WIDTH-1:0]           out_force_y,
  output logic [DATA_WIDTH-1:0]           out_force_z,
  output logic                            wb_busy,
  output logic                            wb_done,
  output logic [3:0]                      wb_count,
  output logic                            overflow
);

  localparam int ENTRY_W = ID_WIDTH + 3*DATA_WIDTH;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   mem_q [NUM_LANES][2];
  logic [ENTRY_W-1:0]   mem_d [NUM_LANES][2];
  logic [NUM_LANES-1:0] head_q, head_d;
  logic [1:0]           count_q [NUM_LANES];
  logic [1:0]           count_d [NUM_LANES];
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [2:0]           out_lane_q, out_lane_d;
  logic [ENTRY_W-1:0]   out_entry_q, out_entry_d;
  logic [3:0]           wb_count_q, wb_count_d;
  logic                 overflow_q, overflow_d;

  logic [ENTRY_W-1:0]   in_entry [NUM_LANES];
  logic [NUM_LANES-1:0] non_empty;
  logic [NUM_LANES-1:0] full;
  logic [NUM_LANES-1:0] pop;
  logic [NUM_LANES-1:0] push;
  logic                 grant_valid;
  logic [2:0]           grant_lane;
  logic [3:0]           arb_sum;
  logic [2:0]           arb_idx;
  logic                 load;
  logic                 handshake;
  logic                 any_push;
  logic                 any_start;
  logic                 all_empty;
  logic                 wb_done_c;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign in_entry[g]  = {in_id[g*ID_WIDTH +: ID_WIDTH],
                           in_force_x[g*DATA_WIDTH +: DATA_WIDTH],
                           in_force_y[g*DATA_WIDTH +: DATA_WIDTH],
                           in_force_z[g*DATA_WIDTH +: DATA_WIDTH]};
    assign non_empty[g] = (count_q[g] != 2'd0);
    assign full[g]      = (count_q[g] == 2'd2);
    assign pop[g]       = load && (grant_lane == 3'(g));
  end

  assign handshake = out_valid_q && out_ready;
  assign load      = grant_valid && (!out_valid_q || out_ready);
  assign any_push  = |in_valid;
  assign any_start = |in_start_wb;
  assign all_empty = (non_empty == '0) && !out_valid_q;

  // Round-robin search starting at rr_ptr, wrapping modulo the lane count.
  always_comb begin
    grant_valid = 1'b0;
    grant_lane  = 3'd0;
    arb_sum     = 4'd0;
    arb_idx     = 3'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + 4'(k);
      if (arb_sum >= 4'(NUM_LANES)) arb_sum = arb_sum - 4'(NUM_LANES);
      arb_idx = arb_sum[2:0];
      if (!grant_valid && non_empty[arb_idx]) begin
        grant_valid = 1'b1;
        grant_lane  = arb_idx;
      end
    end
  end

  // A full FIFO still accepts a push when its head is popped in the same
  // cycle; the write lands in the slot being vacated.
  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    push       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      push[i] = in_valid[i] && (!full[i] || pop[i]);
      if (in_valid[i] && full[i] && !pop[i]) overflow_d = 1'b1;
      if (push[i]) mem_d[i][head_q[i] ^ count_q[i][0]] = in_entry[i];
      if (pop[i]) head_d[i] = ~head_q[i];
      count_d[i] = count_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_lane_d  = out_lane_q;
    out_entry_d = out_entry_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_lane_d  = grant_lane;
      out_entry_d = mem_q[grant_lane][head_q[grant_lane]];
      rr_ptr_d    = (grant_lane == 3'(NUM_LANES-1)) ? 3'd0 : grant_lane + 3'd1;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  // Round tracking: opening a round restarts the handoff count.
  always_comb begin
    state_d    = state_q;
    wb_count_d = wb_count_q;
    wb_done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_push || any_start) begin
          state_d    = ST_ACTIVE;
          wb_count_d = handshake ? 4'd1 : 4'd0;
        end else if (handshake && wb_count_q != 4'd15) begin
          wb_count_d = wb_count_q + 4'd1;
        end
      end
      ST_ACTIVE: begin
        if (handshake && wb_count_q != 4'd15) wb_count_d = wb_count_q + 4'd1;
        if (all_empty && !any_push && !any_start) begin
          state_d   = ST_IDLE;
          wb_done_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      head_q      <= '0;
      for (int i = 0; i < NUM_LANES; i++) count_q[i] <= 2'd0;
      rr_ptr_q    <= 3'd0;
      out_valid_q <= 1'b0;
      out_lane_q  <= 3'd0;
      out_entry_q <= '0;
      wb_count_q  <= 4'd0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_lane_q  <= out_lane_d;
      out_entry_q <= out_entry_d;
      wb_count_q  <= wb_count_d;
      overflow_q  <= overflow_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by the counts.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_stall    = |full;
  assign out_valid   = out_valid_q;
  assign out_lane    = out_lane_q;
  assign out_id      = out_entry_q[ENTRY_W-1 -: ID_WIDTH];
  assign out_force_x = out_entry_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_force_y = out_entry_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_force_z = out_entry_q[DATA_WIDTH-1:0];
  assign wb_busy     = (state_q == ST_ACTIVE);
  assign wb_done     = wb_done_c;
  assign wb_count    = wb_count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ref_force_wb_collector.sv
// Randomized bench for ref_force_wb_collector, checked every cycle against a
// queue-based model of the lane FIFOs, output stage and writeback rounds.
module tb_ref_force_wb_collector;

  localparam int DW  = 32;
  localparam int IDW = 17;
  localparam int NL  = 7;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  fx;
    logic [DW-1:0]  fy;
    logic [DW-1:0]  fz;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NL-1:0]     in_valid = '0;
  logic [NL-1:0]     in_start_wb = '0;
  logic [NL*IDW-1:0] in_id;
  logic [NL*DW-1:0]  in_force_x, in_force_y, in_force_z;
  logic              in_stall;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2:0]        out_lane;
  logic [IDW-1:0]    out_id;
  logic [DW-1:0]     out_force_x, out_force_y, out_force_z;
  logic              wb_busy, wb_done;
  logic [3:0]        wb_count;
  logic              overflow;

  ent_t drvEnt [NL];

  for (genvar g = 0; g < NL; g++) begin : g_pack
    assign in_id[g*IDW +: IDW]     = drvEnt[g].id;
    assign in_force_x[g*DW +: DW]  = drvEnt[g].fx;
    assign in_force_y[g*DW +: DW]  = drvEnt[g].fy;
    assign in_force_z[g*DW +: DW]  = drvEnt[g].fz;
  end

  ref_force_wb_collector dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_start_wb(in_start_wb), .in_id(in_id),
    .in_force_x(in_force_x), .in_force_y(in_force_y), .in_force_z(in_force_z),
    .in_stall(in_stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane(out_lane), .out_id(out_id),
    .out_force_x(out_force_x), .out_force_y(out_force_y), .out_force_z(out_force_z),
    .wb_busy(wb_busy), .wb_done(wb_done), .wb_count(wb_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Behavioural model state
  ent_t mq [NL][$];
  bit   mOv;
  ent_t mOut;
  int   mLane;
  int   mRr;
  bit   mActive;
  int   mCount;
  bit   mOvf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NL; i++) mq[i].delete();
    mOv = 0; mOut = '0; mLane = 0; mRr = 0; mActive = 0; mCount = 0; mOvf = 0;
  endtask

  function automatic bit modelEmpty();
    for (int i = 0; i < NL; i++) if (mq[i].size() != 0) return 1'b0;
    return !mOv;
  endfunction

  function automatic bit modelDone();
    return mActive && modelEmpty() && (in_valid == '0) && (in_start_wb == '0);
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  task automatic modelStep();
    bit   hs, canLoad, done, opening;
    int   g;
    ent_t pe;
    hs      = mOv && out_ready;
    canLoad = !mOv || out_ready;
    done    = modelDone();
    opening = !mActive && ((in_valid != '0) || (in_start_wb != '0));
    g       = -1;
    pe      = '0;
    for (int k = 0; k < NL; k++) begin
      int l;
      l = (mRr + k) % NL;
      if (g < 0 && mq[l].size() > 0) g = l;
    end
    if (!canLoad) g = -1;
    if (g >= 0) pe = mq[g].pop_front();
    for (int i = 0; i < NL; i++) begin
      if (in_valid[i]) begin
        if (mq[i].size() < 2) mq[i].push_back(drvEnt[i]);
        else mOvf = 1;
      end
    end
    if (g >= 0) begin
      mOv = 1; mOut = pe; mLane = g; mRr = (g + 1) % NL;
    end else if (hs) begin
      mOv = 0;
    end
    if (opening) begin
      mActive = 1;
      mCount  = hs ? 1 : 0;
    end else begin
      if (hs && mCount < 15) mCount++;
      if (done) mActive = 0;
    end
  endtask

  task automatic checkOutput();
    bit stall;
    stall = 0;
    for (int i = 0; i < NL; i++) if (mq[i].size() == 2) stall = 1;
    chk("out_valid", out_valid, mOv);
    chk("in_stall", in_stall, stall);
    chk("wb_busy", wb_busy, mActive);
    chk("wb_done", wb_done, modelDone());
    chk("wb_count", wb_count, mCount);
    chk("overflow", overflow, mOvf);
    if (mOv) begin
      chk("out_lane", out_lane, mLane);
      chk("out_id", out_id, mOut.id);
      chk("out_force_x", out_force_x, mOut.fx);
      chk("out_force_y", out_force_y, mOut.fy);
      chk("out_force_z", out_force_z, mOut.fz);
    end
  endtask

  // One clock cycle: inputs are already set (at a negedge) by the caller.
  task automatic applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    in_valid    = '0;
    in_start_wb = '0;
  endtask

  task automatic pushLane(input int lane, input logic [IDW-1:0] id, input logic [DW-1:0] fx);
    in_valid[lane]   = 1'b1;
    drvEnt[lane].id  = id;
    drvEnt[lane].fx  = fx;
    drvEnt[lane].fy  = $urandom;
    drvEnt[lane].fz  = $urandom;
  endtask

  task automatic checkZeroOutputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_lane"}, out_lane, 0);
    chk({tag, "_out_id"}, out_id, 0);
    chk({tag, "_out_fx"}, out_force_x, 0);
    chk({tag, "_out_fy"}, out_force_y, 0);
    chk({tag, "_out_fz"}, out_force_z, 0);
    chk({tag, "_in_stall"}, in_stall, 0);
    chk({tag, "_wb_busy"}, wb_busy, 0);
    chk({tag, "_wb_done"}, wb_done, 0);
    chk({tag, "_wb_count"}, wb_count, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  // Called at a negedge; leaves the DUT out of reset at a negedge.
  task automatic doReset();
    clearInputs();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkZeroOutputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int doneCnt, emitted;
    for (int i = 0; i < NL; i++) drvEnt[i] = '0;
    $display("[TB] start");
    @(negedge clk);
    doReset();

    // Single lane
    out_ready = 1'b1;
    pushLane(3, 17'h01A05, 32'h3F800000);
    applyStimulus();
    clearInputs();
    applyStimulus();
    chk("sl_valid", out_valid, 1);
    chk("sl_lane", out_lane, 3);
    chk("sl_id", out_id, 17'h01A05);
    chk("sl_fx", out_force_x, 32'h3F800000);
    applyStimulus();
    chk("sl_count", wb_count, 1);
    chk("sl_done", wb_done, 1);
    applyStimulus();
    chk("sl_done_low", wb_done, 0);
    chk("sl_idle", wb_busy, 0);

    // All lanes in one cycle
    doReset();
    out_ready = 1'b1;
    for (int i = 0; i < NL; i++) pushLane(i, IDW'($urandom), $urandom);
    applyStimulus();
    clearInputs();
    applyStimulus();
    doneCnt = 0;
    for (int k = 0; k < NL; k++) begin
      chk("al_valid", out_valid, 1);
      chk("al_lane", out_lane, k);
      if (wb_done) doneCnt++;
      applyStimulus();
    end
    chk("al_count", wb_count, 7);
    for (int k = 0; k < 3; k++) begin
      if (wb_done) doneCnt++;
      applyStimulus();
    end
    chk("al_done_pulses", doneCnt, 1);

    // Round-robin after a grant to lane 5
    doReset();
    out_ready = 1'b1;
    pushLane(5, 17'h00005, 32'h5);
    applyStimulus();
    clearInputs();
    pushLane(0, 17'h00010, 32'h10);
    pushLane(6, 17'h00016, 32'h16);
    applyStimulus();
    clearInputs();
    applyStimulus();
    chk("rr_first", out_lane, 6);
    applyStimulus();
    chk("rr_second", out_lane, 0);
    applyStimulus();

    // Backpressure on lane 2: first push moves into the output stage
    doReset();
    pushLane(2, 17'h00A01, 32'hA1);
    applyStimulus();
    pushLane(2, 17'h00A02, 32'hA2);
    applyStimulus();
    chk("bp_stall_after2", in_stall, 0);
    pushLane(2, 17'h00A03, 32'hA3);
    applyStimulus();
    chk("bp_stall_after3", in_stall, 1);
    chk("bp_ovf_after3", overflow, 0);
    pushLane(2, 17'h00A04, 32'hA4);
    applyStimulus();
    chk("bp_ovf_after4", overflow, 1);
    clearInputs();
    for (int k = 0; k < 6; k++) begin
      chk("bp_hold_id", out_id, 17'h00A01);
      applyStimulus();
    end
    out_ready = 1'b1;
    emitted = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) emitted++;
      applyStimulus();
    end
    chk("bp_emitted", emitted, 3);

    // Simultaneous push and pop on a full lane 1
    doReset();
    pushLane(1, 17'h00B01, 32'hB1);
    applyStimulus();
    pushLane(1, 17'h00B02, 32'hB2);
    applyStimulus();
    pushLane(1, 17'h00B03, 32'hB3);
    applyStimulus();
    clearInputs();
    chk("pp_full", in_stall, 1);
    out_ready = 1'b1;
    pushLane(1, 17'h00B04, 32'hB4);
    applyStimulus();
    clearInputs();
    chk("pp_ovf", overflow, 0);
    chk("pp_still_full", in_stall, 1);
    chk("pp_out_id", out_id, 17'h00B02);
    for (int k = 0; k < 6; k++) applyStimulus();

    // Reset mid-round
    doReset();
    for (int i = 0; i < 4; i++) pushLane(i, IDW'(i + 32), $urandom);
    applyStimulus();
    clearInputs();
    chk("mr_busy", wb_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkZeroOutputs("mr");
    @(negedge clk);
    chk("mr_no_done", wb_done, 0);
    @(negedge clk);
    chk("mr_no_done2", wb_done, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    pushLane(4, 17'h00C04, 32'hC4);
    applyStimulus();
    clearInputs();
    chk("mr_fresh_busy", wb_busy, 1);
    chk("mr_fresh_count", wb_count, 0);
    applyStimulus();
    applyStimulus();
    chk("mr_fresh_count1", wb_count, 1);

    // Randomized traffic with bursty pushes, occasional starts and backpressure
    doReset();
    for (int c = 0; c < 3000; c++) begin
      int rate;
      rate = ((c / 40) % 3 == 0) ? 0 : (((c / 40) % 3 == 1) ? 22 : 8);
      for (int i = 0; i < NL; i++) begin
        in_valid[i] = ($urandom_range(0, 99) < rate);
        in_start_wb[i] = ($urandom_range(0, 199) == 0);
        drvEnt[i].id = IDW'($urandom);
        drvEnt[i].fx = $urandom;
        drvEnt[i].fy = $urandom;
        drvEnt[i].fz = $urandom;
      end
      out_ready = ((c / 100) % 5 == 4) ? 1'b0 : ($urandom_range(0, 99) < 75);
      applyStimulus();
    end
    clearInputs();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) applyStimulus();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
